rr_arbiter_hold: RTL and testbench

Parametrised N-way round-robin arbiter with grant hold and a bounded burst length, the next-generation replacement for the fixed-priority five-input per-output-port arbiters in the router. One instance sits on each router output port. It grants the crossbar to one input at a time and keeps the grant while that input's request stays asserted. It rotates priority so that no input starves, and it force-releases a holder after MAXHOLD cycles when other inputs are waiting.

---
 rtl/rr_arbiter_hold.sv | 143 ++++++++++++++
 tb/tb_rr_arbiter_hold.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_hold.sv
// N-way round-robin crossbar arbiter with grant hold and a bounded burst length.
// One instance per router output port; every release passes through one IDLE bubble.
module rr_arbiter_hold #(
    parameter int unsigned N       = 5,
    parameter int unsigned MAXHOLD = 16,
    parameter int unsigned IDW     = (N > 1) ? $clog2(N) : 1,
    parameter int unsigned CW      = (MAXHOLD > 0) ? $clog2(MAXHOLD + 1) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_vld,
    output logic [IDW-1:0] gnt_id,
    output logic           expire
);

    localparam int unsigned SW = IDW + 1;

    localparam logic [1:0] S_IDLE  = 2'b01;
    localparam logic [1:0] S_GRANT = 2'b10;

    localparam logic [IDW-1:0] LAST_IDX  = IDW'(N - 1);
    localparam logic [CW-1:0]  HOLD_MAX  = CW'(MAXHOLD);
    localparam logic [SW-1:0]  N_WIDE    = SW'(N);

    logic [1:0]     state_q,    state_d;
    logic [IDW-1:0] owner_q,    owner_d;
    logic [IDW-1:0] ptr_q,      ptr_d;
    logic [CW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [N-1:0]   gnt_q,      gnt_d;
    logic           gnt_vld_q,  gnt_vld_d;
    logic [IDW-1:0] gnt_id_q,   gnt_id_d;
    logic           expire_q,   expire_d;

    logic [SW-1:0]  scan_idx;
    logic [IDW-1:0] win_idx;
    logic           win_found;
    logic [N-1:0]   others;

    // Round-robin scan starting at ptr, wrapping by explicit compare against N.
    always_comb begin
        scan_idx  = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            scan_idx = SW'(ptr_q) + SW'(k);
            if (scan_idx >= N_WIDE) begin
                scan_idx = scan_idx - N_WIDE;
            end
            if (!win_found && req[scan_idx[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[IDW-1:0];
            end
        end
    end

    assign others = req & ~(N'(1) << owner_q);

    // Next-state and next-output decode.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        expire_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ptr_q > LAST_IDX) begin
                    ptr_d = '0;
                end else if (win_found) begin
                    state_d    = S_GRANT;
                    owner_d    = win_idx;
                    ptr_d      = (win_idx == LAST_IDX) ? '0 : win_idx + IDW'(1);
                    hold_cnt_d = CW'(1);
                end
            end
            S_GRANT: begin
                if (owner_q > LAST_IDX) begin
                    state_d    = S_IDLE;
                    owner_d    = '0;
                    hold_cnt_d = '0;
                end else if (!req[owner_q]) begin
                    state_d    = S_IDLE;
                    hold_cnt_d = '0;
                end else if ((MAXHOLD == 0) || (hold_cnt_q < HOLD_MAX)) begin
                    if (MAXHOLD != 0) begin
                        hold_cnt_d = hold_cnt_q + CW'(1);
                    end
                end else if (|others) begin
                    // Burst limit reached with someone waiting: forced release.
                    state_d    = S_IDLE;
                    hold_cnt_d = '0;
                    expire_d   = 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                owner_d    = '0;
                ptr_d      = '0;
                hold_cnt_d = '0;
            end
        endcase

        gnt_d     = '0;
        gnt_vld_d = 1'b0;
        gnt_id_d  = '0;
        if (state_d == S_GRANT) begin
            gnt_d     = N'(1) << owner_d;
            gnt_vld_d = 1'b1;
            gnt_id_d  = owner_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            gnt_vld_q  <= 1'b0;
            gnt_id_q   <= '0;
            expire_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_vld_q  <= gnt_vld_d;
            gnt_id_q   <= gnt_id_d;
            expire_q   <= expire_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_vld = gnt_vld_q;
    assign gnt_id  = gnt_id_q;
    assign expire  = expire_q;

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Scoreboard bench for rr_arbiter_hold: one unlimited-hold and one MAXHOLD=4 instance.
module tb_rr_arbiter_hold;

    logic       clk;
    logic       rst;
    logic [4:0] req0, req4;
    logic [4:0] gnt0, gnt4;
    logic       vld0, vld4;
    logic [2:0] id0, id4;
    logic       exp0, exp4;

    int checks = 0;
    int errors = 0;
    int vec_n  = 0;

    typedef struct {
        bit         sel;
        logic [4:0] gnt;
        logic       expire;
        int         idx;
    } exp_t;

    exp_t sb[$];

    rr_arbiter_hold #(.N(5), .MAXHOLD(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0),
        .gnt(gnt0), .gnt_vld(vld0), .gnt_id(id0), .expire(exp0)
    );

    rr_arbiter_hold #(.N(5), .MAXHOLD(4)) dut4 (
        .clk(clk), .rst(rst), .req(req4),
        .gnt(gnt4), .gnt_vld(vld4), .gnt_id(id4), .expire(exp4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] oh2idx(input logic [4:0] oh);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            if (oh[i]) r = 3'(i);
        end
        return r;
    endfunction

    function automatic void chk(input string nm, input int v, input logic [4:0] act, input logic [4:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s vec%0d: got %b, want %b", nm, v, act, want);
        end
    endfunction

    // Monitor: pops one expected entry per cycle, sampled 1 ns after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.sel) begin
                    chk("gnt4",    e.idx, gnt4,         e.gnt);
                    chk("vld4",    e.idx, {4'b0, vld4}, {4'b0, |e.gnt});
                    chk("id4",     e.idx, {2'b0, id4},  {2'b0, oh2idx(e.gnt)});
                    chk("expire4", e.idx, {4'b0, exp4}, {4'b0, e.expire});
                end else begin
                    chk("gnt0",    e.idx, gnt0,         e.gnt);
                    chk("vld0",    e.idx, {4'b0, vld0}, {4'b0, |e.gnt});
                    chk("id0",     e.idx, {2'b0, id0},  {2'b0, oh2idx(e.gnt)});
                    chk("expire0", e.idx, {4'b0, exp0}, {4'b0, e.expire});
                end
            end
        end
    end

    // Drive one cycle of stimulus and push the response expected after the next edge.
    task automatic vec(input bit sel, input bit rst_v, input logic [4:0] req_v,
                       input logic [4:0] g, input bit e);
        exp_t x;
        @(negedge clk);
        rst  = rst_v;
        req0 = sel ? 5'b0 : req_v;
        req4 = sel ? req_v : 5'b0;
        x.sel = sel; x.gnt = g; x.expire = e; x.idx = vec_n;
        sb.push_back(x);
        vec_n++;
    endtask

    task automatic rep(input int n, input bit sel, input bit rst_v, input logic [4:0] req_v,
                       input logic [4:0] g, input bit e);
        for (int i = 0; i < n; i++) vec(sel, rst_v, req_v, g, e);
    endtask

    initial begin
        int cnt [5];
        int mx, mn;
        rst  = 1'b0;
        req0 = '0;
        req4 = '0;

        // Reset with full load, then rotation through bursts of 4 (MAXHOLD=4)
        rep(2, 1, 0, 5'b11111, 5'b00000, 0);
        rep(4, 1, 1, 5'b11111, 5'b00001, 0);
        rep(1, 1, 1, 5'b11111, 5'b00000, 1);
        rep(4, 1, 1, 5'b11111, 5'b00010, 0);
        rep(1, 1, 1, 5'b11111, 5'b00000, 1);
        rep(4, 1, 1, 5'b11111, 5'b00100, 0);
        rep(1, 1, 1, 5'b11111, 5'b00000, 1);
        rep(2, 1, 1, 5'b11111, 5'b01000, 0);
        // Mid-grant reset, then arbitration restarts from input 0
        rep(1, 1, 0, 5'b11111, 5'b00000, 0);
        rep(1, 1, 1, 5'b11111, 5'b00001, 0);
        rep(1, 1, 1, 5'b00000, 5'b00000, 0);

        // Burst limit: inputs 1 and 3 alternate
        rep(4, 1, 1, 5'b01010, 5'b00010, 0);
        rep(1, 1, 1, 5'b01010, 5'b00000, 1);
        rep(4, 1, 1, 5'b01010, 5'b01000, 0);
        rep(1, 1, 1, 5'b01010, 5'b00000, 1);
        rep(4, 1, 1, 5'b01010, 5'b00010, 0);
        rep(1, 1, 1, 5'b01010, 5'b00000, 1);
        rep(2, 1, 1, 5'b01010, 5'b01000, 0);
        rep(1, 1, 1, 5'b00000, 5'b00000, 0);

        // Uncontended holder is never cut
        rep(20, 1, 1, 5'b00100, 5'b00100, 0);
        rep(1,  1, 1, 5'b00000, 5'b00000, 0);

        // Wrap: ptr=4 after granting 3, so input 4 beats input 0
        rep(1, 1, 1, 5'b01000, 5'b01000, 0);
        rep(1, 1, 1, 5'b00000, 5'b00000, 0);
        rep(3, 1, 1, 5'b10001, 5'b10000, 0);
        rep(1, 1, 1, 5'b00001, 5'b00000, 0);
        rep(1, 1, 1, 5'b00001, 5'b00001, 0);
        rep(1, 1, 1, 5'b00000, 5'b00000, 0);

        // Unlimited hold (MAXHOLD=0): hold, release bubble, rotation
        rep(4,  0, 1, 5'b00101, 5'b00001, 0);
        rep(1,  0, 1, 5'b00100, 5'b00000, 0);
        rep(6,  0, 1, 5'b00100, 5'b00100, 0);
        rep(1,  0, 1, 5'b00001, 5'b00000, 0);
        rep(1,  0, 1, 5'b00001, 5'b00001, 0);
        rep(20, 0, 1, 5'b00101, 5'b00001, 0);
        rep(1,  0, 1, 5'b00000, 5'b00000, 0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left, want 0", sb.size());
        end

        // Fairness under full load on the MAXHOLD=4 instance
        for (int i = 0; i < 5; i++) cnt[i] = 0;
        @(negedge clk);
        req4 = 5'b11111;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (!$onehot0(gnt4) || (vld4 !== (|gnt4))) begin
                errors++;
                $display("FAIL onehot cycle%0d: got gnt %b vld %b, want one-hot/zero with vld=|gnt", c, gnt4, vld4);
            end
            for (int i = 0; i < 5; i++) if (gnt4[i]) cnt[i]++;
        end
        mx = cnt[0];
        mn = cnt[0];
        for (int i = 1; i < 5; i++) begin
            if (cnt[i] > mx) mx = cnt[i];
            if (cnt[i] < mn) mn = cnt[i];
        end
        checks++;
        if ((mx - mn) > 4 || mn == 0) begin
            errors++;
            $display("FAIL fairness: got max %0d min %0d, want spread <= 4 and min > 0", mx, mn);
        end
        @(negedge clk);
        req4 = '0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
